// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - MIPS execute/write-back stage: one-hot ALU over a 32x32 register file
module alu_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic [5:0]  alu_ctrl,
   input  logic        reg_write,
   input  logic        ld_en,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   input  logic        ovf_clr,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        ovf,
   output logic        illegal
);

   logic [31:0] regs [32];
   logic [4:0]  rs, rt, rd;
   logic [31:0] a, b, alu_out, sum;
   logic        legal, add_ovf, commit;
   logic        unused_bits;

   assign rs = instruction[25:21];
   assign rt = instruction[20:16];
   assign rd = instruction[15:11];
   assign unused_bits = ^{instruction[31:26], instruction[10:0]};

   assign a        = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign b        = (rt == 5'd0) ? 32'd0 : regs[rt];
   assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];
   assign sum      = a + b;

   always_comb begin
      alu_out = 32'd0;
      legal   = 1'b1;
      add_ovf = 1'b0;
      case (alu_ctrl)
         6'b000001: alu_out = sum;
         6'b000010: alu_out = a - b;
         6'b000100: begin
            alu_out = sum;
            add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         6'b001000: alu_out = a & b;
         6'b010000: alu_out = a | b;
         6'b100000: alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default:   legal   = 1'b0;
      endcase
   end

   assign commit = reg_write && legal && !add_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
         result       <= 32'd0;
         result_valid <= 1'b0;
         ovf          <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         result_valid <= commit;
         illegal      <= reg_write && !legal;
         if (commit) result <= alu_out;
         if (commit && rd != 5'd0) regs[rd] <= alu_out;
         // Side load is assigned last so it wins a same-index conflict.
         if (ld_en && ld_addr != 5'd0) regs[ld_addr] <= ld_data;
         if (reg_write && add_ovf) ovf <= 1'b1;
         else if (ovf_clr)         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - randomized and directed check of alu_regfile against a behavioural model
module tb_alu_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction;
   logic [5:0]  alu_ctrl;
   logic        reg_write;
   logic        ld_en;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ovf_clr;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] result;
   logic        result_valid;
   logic        ovf;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_reg [32];
   logic [31:0] m_result;
   logic        m_ovf;

   alu_regfile dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction), .alu_ctrl(alu_ctrl),
      .reg_write(reg_write), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ovf_clr(ovf_clr), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .result(result),
      .result_valid(result_valid), .ovf(ovf), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic peek(input logic [4:0] idx, input logic [31:0] exp, input string tag);
      dbg_addr = idx;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_result = 32'd0;
      m_ovf    = 1'b0;
   endtask

   task automatic idle();
      instruction = 32'd0; alu_ctrl = 6'd0; reg_write = 1'b0;
      ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'd0; ovf_clr = 1'b0; dbg_addr = 5'd0;
   endtask

   // One cycle: drive at negedge, predict from the architectural rules, check after the edge.
   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] ctrl, input logic rw, input logic le,
                       input logic [4:0] la, input logic [31:0] ld, input logic oc);
      logic [31:0] a, b, r;
      logic        legal, ov, e_valid, e_ill;
      longint      s;
      a = m_reg[rs]; b = m_reg[rt]; r = 32'd0; legal = 1'b1; ov = 1'b0;
      case (ctrl)
         6'd1:  r = a + b;
         6'd2:  r = a - b;
         6'd4:  begin
            s  = longint'(int'(a)) + longint'(int'(b));
            r  = a + b;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'd8:  r = a & b;
         6'd16: r = a | b;
         6'd32: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         default: legal = 1'b0;
      endcase
      instruction = {6'd0, rs, rt, rd, 11'd0};
      alu_ctrl = ctrl; reg_write = rw; ld_en = le; ld_addr = la; ld_data = ld; ovf_clr = oc;
      dbg_addr = rd;
      #1;
      chk("pre_edge_rd", dbg_data, m_reg[rd]);
      e_valid = rw && legal && !ov;
      e_ill   = rw && !legal;
      if (rw && ov) m_ovf = 1'b1;
      else if (oc)  m_ovf = 1'b0;
      if (e_valid) m_result = r;
      if (e_valid && rd != 5'd0) m_reg[rd] = r;
      if (le && la != 5'd0) m_reg[la] = ld;
      @(posedge clk);
      #1;
      chk("result", result, m_result);
      chk("result_valid", {31'd0, result_valid}, {31'd0, e_valid});
      chk("illegal", {31'd0, illegal}, {31'd0, e_ill});
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      chk("post_edge_rd", dbg_data, m_reg[rd]);
      peek(la, m_reg[la], "post_edge_ld");
      @(negedge clk);
      idle();
   endtask

   task automatic load(input logic [4:0] la, input logic [31:0] ld);
      step(5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1, la, ld, 1'b0);
   endtask

   task automatic op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [5:0] ctrl);
      step(rs, rt, rd, ctrl, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_result"}, result, 32'd0);
      chk({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
      chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
      chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
   endtask

   initial begin
      logic [5:0] ctrls [7];
      logic [31:0] prev;
      ctrls = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd0};
      idle();
      model_reset();
      rst_n = 1'b0;
      #12;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) peek(i[4:0], 32'd0, "reset_reg");
      @(negedge clk);

      // addu/subu wrap
      load(5'd1, 32'hFFFF_FFFF);
      load(5'd2, 32'd2);
      op(5'd1, 5'd2, 5'd3, 6'b000001);
      peek(5'd3, 32'h0000_0001, "addu_wrap");
      op(5'd2, 5'd1, 5'd4, 6'b000010);
      peek(5'd4, 32'h0000_0003, "subu_wrap");

      // add overflow, clear, clear coincident with new overflow
      load(5'd1, 32'h7FFF_FFFF);
      load(5'd2, 32'd1);
      prev = result;
      op(5'd1, 5'd2, 5'd5, 6'b000100);
      peek(5'd5, 32'd0, "add_ovf_no_write");
      chk("add_ovf_result_held", result, prev);
      chk("add_ovf_flag", {31'd0, ovf}, 32'd1);
      step(5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      chk("ovf_cleared", {31'd0, ovf}, 32'd0);
      op(5'd1, 5'd2, 5'd5, 6'b000100);
      step(5'd1, 5'd2, 5'd5, 6'b000100, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
      chk("ovf_set_beats_clr", {31'd0, ovf}, 32'd1);
      step(5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

      // slt/and/or
      load(5'd1, 32'hFFFF_FFFE);
      load(5'd2, 32'd3);
      op(5'd1, 5'd2, 5'd6, 6'b100000);
      peek(5'd6, 32'd1, "slt_true");
      op(5'd2, 5'd1, 5'd6, 6'b100000);
      peek(5'd6, 32'd0, "slt_false");
      op(5'd1, 5'd2, 5'd8, 6'b001000);
      peek(5'd8, 32'h0000_0002, "and");
      op(5'd1, 5'd2, 5'd9, 6'b010000);
      peek(5'd9, 32'hFFFF_FFFF, "or");

      // illegal op and rd=0
      op(5'd1, 5'd2, 5'd10, 6'b000011);
      peek(5'd10, 32'd0, "illegal_no_write");
      op(5'd1, 5'd2, 5'd0, 6'b000001);
      chk("rd0_result", result, 32'h0000_0001);
      peek(5'd0, 32'd0, "rd0_reads_zero");

      // side load vs ALU write conflict, then dependent chain
      step(5'd1, 5'd2, 5'd7, 6'b000001, 1'b1, 1'b1, 5'd7, 32'hAAAA_0000, 1'b0);
      peek(5'd7, 32'hAAAA_0000, "conflict_ld_wins");
      op(5'd7, 5'd2, 5'd7, 6'b000001);
      op(5'd7, 5'd2, 5'd7, 6'b000001);
      peek(5'd7, 32'hAAAA_0006, "dependent_chain");

      // randomized traffic, addresses biased to a small window to create hazards
      for (int n = 0; n < 400; n++) begin
         logic [5:0] c;
         logic [31:0] d;
         c = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ctrls[$urandom_range(0, 6)];
         case ($urandom_range(0, 3))
            0: d = 32'h7FFF_FFFF;
            1: d = 32'h8000_0000;
            default: d = $urandom;
         endcase
         step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              c, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 7)), d, 1'($urandom_range(0, 5) == 0));
      end

      // asynchronous reset mid-cycle discards an in-flight commit
      load(5'd11, 32'h1234_5678);
      instruction = {6'd0, 5'd11, 5'd11, 5'd12, 11'd0};
      alu_ctrl = 6'b000001; reg_write = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_reset");
      @(posedge clk);
      #1;
      check_reset_state("reset_held");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 32; i++) peek(i[4:0], 32'd0, "midrun_reset_reg");
      @(negedge clk);
      op(5'd0, 5'd0, 5'd1, 6'b000001);
      chk("post_reset_valid", {31'd0, result_valid}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Execute/write-back stage of the single-cycle MIPS core, directly downstream of the funct decoder. Consumes the decoder's 6-bit one-hot `alu_ctrl` together with the R-type instruction word. Reads `rs`/`rt` from a 32×32 register file, performs the selected ALU operation and writes the result to `rd` on the rising clock edge. A registered result port, an overflow flag and an illegal-op pulse are exported for the rest of the core. A side load port lets upstream logic (or a bench) initialise registers.

## Interface
- No parameters; data width 32, register count 32 fixed.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  R-type word; `rs`=[25:21], `rt`=[20:16], `rd`=[15:11].
- `alu_ctrl`  in  6  one-hot op from decoder.
- `reg_write`  in  1  instruction valid this cycle; enables commit.
- `ld_en`  in  1  side-load write enable.
- `ld_addr`  in  5  side-load register index.
- `ld_data`  in  32  side-load value.
- `ovf_clr`  in  1  clears sticky overflow flag.
- `dbg_addr`  in  5  debug read index.
- `dbg_data`  out  32  combinational read of `dbg_addr`; always 0 for index 0.
- `result`  out  32  registered ALU result of last committed op.
- `result_valid`  out  1  one-cycle pulse after a committed op.
- `ovf`  out  1  sticky signed-overflow flag.
- `illegal`  out  1  one-cycle pulse after an unrecognised `alu_ctrl`.

## Operation
- Operand reads are combinational: `a = R[rs]`, `b = R[rt]`. `R[0]` always reads 0.
- Op encoding:
  - `000001` addu: `a+b` mod 2^32.
  - `000010` subu: `a-b` mod 2^32.
  - `000100` add: `a+b`. Signed overflow when `a[31]==b[31]` and `sum[31]!=a[31]`.
  - `001000` and.
  - `010000` or.
  - `100000` slt: signed compare, result 32'd1 if a<b else 0.
- Any other `alu_ctrl` value (zero, multi-hot) with `reg_write`=1:
  - No register write; `result` holds its value.
  - `illegal`=1 next cycle; `result_valid`=0.
- add with overflow:
  - No register write; `result` holds its value.
  - `result_valid`=0; `ovf` set and held.
- Legal op, no overflow, `reg_write`=1:
  - `R[rd]` written; `result` loaded; `result_valid`=1 next cycle.
  - `rd`=0: the register write is dropped, but `result`/`result_valid` still update.
- `reg_write`=0: no state change except the side load and `ovf_clr`.
- Side load: `ld_en` writes `ld_data` to `R[ld_addr]`; writes to index 0 are ignored.
- Same-cycle side-load and ALU write to the same nonzero index: the side load wins. Different indices are both written.
- `ovf` clear/set: `ovf_clr` clears `ovf`. If a new overflow occurs in the same cycle, set wins.

## Timing
- Reset (async, while `rst_n`=0):
  - All 32 registers cleared to 0.
  - `result`=0, `result_valid`=0, `ovf`=0, `illegal`=0.
  - Takes effect immediately, including mid-cycle; an in-flight commit is discarded.
  - Outputs hold reset values until the first rising edge after deassertion.
- Commit latency: a write to `rd` is visible to combinational reads (operands and `dbg_data`) right after the committing edge. The next instruction reads the new value with no forwarding needed.
- `result`, `result_valid`, `illegal` and `ovf` change only on rising edges, one cycle after the instruction is presented.
- `result_valid` and `illegal` are single-cycle pulses. They re-assert on consecutive cycles for back-to-back qualifying instructions.
- Read-during-write on the same index returns the old value within the cycle; the new value appears after the edge.
- There is no stall or backpressure: one instruction is accepted per cycle whenever `reg_write`=1.

## Test plan
- **Reset:** hold `rst_n`=0 mid-run, then release → `dbg_data`=0 for all 32 indices; `result`=0; `ovf`=0.
- **addu/subu wrap:** load R1=0xFFFFFFFF, R2=2.
  - addu rd=3 → R3=0x00000001, `result_valid` pulse.
  - subu rs=2, rt=1, rd=4 → R4=0x00000003.
- **add overflow:** load R1=0x7FFFFFFF, R2=1; add rd=5 → R5 stays 0, `result` unchanged, `ovf`=1.
  - `ovf_clr` → 0.
  - `ovf_clr` coincident with a second overflow → `ovf` stays 1.
- **slt/and/or:** R1=0xFFFFFFFE (−2), R2=3.
  - slt rd=6 → 1.
  - slt rs=2, rt=1 → 0.
  - and → 0x00000002.
  - or → 0xFFFFFFFF.
- **Illegal and rd=0:**
  - `alu_ctrl`=000011 → `illegal` pulse, no write.
  - addu with rd=0 → `result`=sum, `result_valid`=1, R0 reads 0.
- **Write conflict:** same-cycle `ld_en` to R7=0xAAAA0000 and addu rd=7 → R7=0xAAAA0000.
  - Back-to-back dependent addu instructions read the updated R7.
